// File: rtl/snake_dir_if.sv
// Signal bundle between the snake game logic and snake_dir_ctrl.
// master = game side (drives buttons and events), slave = snake_dir_ctrl.
interface snake_dir_if;
  // No valid/ready backpressure: I_eat, I_game_over, O_step and O_restart are
  // single-cycle strobes that count as taken in the cycle they are high; buttons are levels.
  logic       I_button_u;
  logic       I_button_d;
  logic       I_button_l;
  logic       I_button_r;
  logic       I_eat;
  logic       I_game_over;
  logic [1:0] O_dir;
  logic       O_step;
  logic       O_running;
  logic       O_restart;
  logic [1:0] dbg_state;

  modport master (
    output I_button_u, I_button_d, I_button_l, I_button_r, I_eat, I_game_over,
    input  O_dir, O_step, O_running, O_restart, dbg_state
  );

  modport slave (
    input  I_button_u, I_button_d, I_button_l, I_button_r, I_eat, I_game_over,
    output O_dir, O_step, O_running, O_restart, dbg_state
  );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake direction/pacing controller: press edge detect, reversal reject, step strobe, game FSM.
// Optional speed-up on food is enabled by defining SNAKE_SPEEDUP_EN.
module snake_dir_ctrl #(
  parameter int unsigned STEP_DIV = 5_000_000,
  parameter int unsigned STEP_MIN = 1_500_000,
  parameter int unsigned STEP_DEC = 250_000
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  snake_dir_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [31:0] DIV_W = 32'(STEP_DIV);
  localparam logic [31:0] MIN_W = 32'(STEP_MIN);
  localparam logic [31:0] DEC_W = 32'(STEP_DEC);
  localparam logic [1:0]  DIR_R = 2'd3;

  state_t      state_q, state_d;
  logic [3:0]  btn_q, btn_qq, rise;
  logic        press;
  logic [1:0]  press_code;
  logic [1:0]  dir_q, dir_d, pend_q, pend_d;
  logic [31:0] cnt_q, cnt_d, period_q, period_d;
  logic        armed_q, armed_d;
  logic        step_q, step_d, restart_q, restart_d;
  logic        wrap;

`ifdef SNAKE_SPEEDUP_EN
  logic [31:0] next_q, next_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.I_eat, MIN_W, DEC_W};
`endif

  // Bit index equals the direction code, so the priority chain below is U > D > L > R.
  assign rise  = btn_q & ~btn_qq;
  assign press = |rise;

  always_comb begin
    press_code = DIR_R;
    if (rise[0])      press_code = 2'd0;
    else if (rise[1]) press_code = 2'd1;
    else if (rise[2]) press_code = 2'd2;
  end

  assign wrap = armed_q && (cnt_q == period_q - 32'd1);

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    armed_d   = armed_q;
    step_d    = 1'b0;
    restart_d = 1'b0;
`ifdef SNAKE_SPEEDUP_EN
    next_d    = next_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (press) begin
          dir_d   = press_code;
          pend_d  = press_code;
          cnt_d   = '0;
          armed_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (press && (press_code != (dir_q ^ 2'b01))) pend_d = press_code;
`ifdef SNAKE_SPEEDUP_EN
        if (bus.I_eat) next_d = ((next_q - MIN_W) >= DEC_W) ? (next_q - DEC_W) : MIN_W;
`endif
        // The first RUN cycle only arms the counter, putting the first step STEP_DIV+1 out.
        if (bus.I_game_over) begin
          state_d = ST_OVER;
          cnt_d   = '0;
          armed_d = 1'b0;
        end else if (!armed_q) begin
          armed_d = 1'b1;
        end else if (wrap) begin
          cnt_d  = '0;
          step_d = 1'b1;
          dir_d  = pend_q;
`ifdef SNAKE_SPEEDUP_EN
          period_d = next_d;
`endif
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_OVER: begin
        if (press) begin
          restart_d = 1'b1;
          dir_d     = DIR_R;
          pend_d    = DIR_R;
          period_d  = DIV_W;
`ifdef SNAKE_SPEEDUP_EN
          next_d    = DIV_W;
`endif
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= ST_IDLE;
      btn_q     <= '0;
      btn_qq    <= '0;
      dir_q     <= DIR_R;
      pend_q    <= DIR_R;
      cnt_q     <= '0;
      period_q  <= DIV_W;
      armed_q   <= 1'b0;
      step_q    <= 1'b0;
      restart_q <= 1'b0;
`ifdef SNAKE_SPEEDUP_EN
      next_q    <= DIV_W;
`endif
    end else begin
      state_q   <= state_d;
      btn_q     <= {bus.I_button_r, bus.I_button_l, bus.I_button_d, bus.I_button_u};
      btn_qq    <= btn_q;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      armed_q   <= armed_d;
      step_q    <= step_d;
      restart_q <= restart_d;
`ifdef SNAKE_SPEEDUP_EN
      next_q    <= next_d;
`endif
    end
  end

  assign bus.O_dir     = dir_q;
  assign bus.O_step    = step_q;
  assign bus.O_running = (state_q == ST_RUN);
  assign bus.O_restart = restart_q;
  assign bus.dbg_state = state_q;

endmodule

// File: doc/snake_dir_ctrl.md
# snake_dir_ctrl

Direction and pacing controller for the snake game. It sits between the button debouncer and the snake movement logic. It turns debounced button levels into a committed movement direction, rejects 180° reversals, and generates the periodic one-cycle move strobe that advances the snake. A small game-state machine gates stepping on start and game-over, and an optional speed-up shortens the step period each time food is eaten.

## Interface
- STEP_DIV, 5_000_000, initial step period in I_clk cycles (20 Hz at 100 MHz); must be ≥ 2
- STEP_MIN, 1_500_000, floor of the step period when speed-up is enabled; 2 ≤ STEP_MIN ≤ STEP_DIV
- STEP_DEC, 250_000, period decrement per I_eat pulse when speed-up is enabled
- I_clk  in  1  system clock
- I_rst_n  in  1  reset; asynchronous, active-low
- I_button_u / I_button_d / I_button_l / I_button_r  in  1 each  debounced button levels, high = pressed
- I_eat  in  1  one-cycle pulse: snake head reached the box
- I_game_over  in  1  one-cycle pulse: collision detected
- O_dir  out  2  committed direction: 0 = up, 1 = down, 2 = left, 3 = right
- O_step  out  1  one-cycle move strobe
- O_running  out  1  high while in RUN
- O_restart  out  1  one-cycle pulse on leaving OVER

## Operation
- Reset values: state IDLE, O_dir = 3, O_step = 0, O_running = 0, O_restart = 0, pending = 3, counter = 0, period = STEP_DIV.
- Press detection: each button is registered once. A press is a registered 0→1 transition. If several presses occur in the same cycle, priority is U > D > L > R; only the winning press is used.
- Opposite of d is d ^ 2'b01. A press whose code equals ~opposite(O_dir)... is rejected when its code equals opposite(O_dir); otherwise it overwrites pending. Presses are always checked against the committed O_dir, never against pending.
- IDLE:
  - Any press, including a reverse of O_dir, loads pending and O_dir with that code, clears the counter and enters RUN.
  - O_step stays 0.
- RUN:
  - Counter counts 0 .. period−1.
  - In the cycle where counter == period−1, the counter wraps to 0. In the next cycle O_step = 1 and O_dir = pending.
  - I_game_over enters OVER, clears the counter and suppresses any step due in that cycle.
- OVER:
  - O_step stays 0.
  - Any press pulses O_restart for one cycle, sets O_dir = pending = 3, resets period to STEP_DIV and enters IDLE.
  - That press is consumed; it does not start RUN.
- Counter and period are 32 bits, unsigned. Period subtraction saturates at STEP_MIN; it never underflows.

## Timing
- Press to pending: two cycles after the raw level rises (one cycle for the input register, one for the update).
- RUN entry to first O_step: exactly STEP_DIV + 1 cycles after the cycle in which O_running first reads 1. After that, one O_step every `period` cycles.
- O_dir changes only in an O_step cycle or on an IDLE/OVER transition.
- A press edge in the same cycle as the counter wrap is not part of that step. It applies at the next step.
- I_game_over and a wrap in the same cycle: game-over wins and no step is issued.
- I_eat outside RUN is ignored.
- Asserting I_rst_n low mid-operation forces all reset values immediately, with no pulse outputs.

## Configuration
- SNAKE_SPEEDUP_EN defined:
  - Each I_eat in RUN computes next_period = max(period − STEP_DEC, STEP_MIN).
  - next_period is loaded into period only at the next counter wrap, so the current interval is never shortened mid-count.
  - Several I_eat pulses before a wrap each decrement the pending value.
- SNAKE_SPEEDUP_EN undefined:
  - I_eat is ignored; period is fixed at STEP_DIV.
  - Port list is identical in both builds.

## Test plan
- Bench uses STEP_DIV = 10, STEP_MIN = 4, STEP_DEC = 3.
- Reset, no input for 100 cycles -> O_dir = 3, O_step never high, O_running = 0.
- Pulse I_button_u in IDLE -> O_dir = 0 and O_running = 1; first O_step 11 cycles later, then every 10 cycles.
- In RUN with O_dir = 3: press L, then U within one interval -> L is rejected, U is accepted; next O_step sets O_dir = 0.
- U and R pressed in the same cycle while O_dir = 2 -> U wins and O_dir becomes 0 at the next step.
- I_game_over coincident with a wrap -> no O_step, O_running drops; a later press gives a one-cycle O_restart, O_dir = 3, state IDLE.
- With SNAKE_SPEEDUP_EN: three I_eat pulses in separate intervals -> intervals 10, 7, 4, 4; without the macro -> all intervals stay 10.
